// File: rtl/core_dma_rd_initiator.sv
// core_dma_rd_initiator
//   Initiator side of the per-core DMA read path. A byte-length request is split into
//   line-sized read commands. In-order line responses are reframed as a stream carrying
//   byte enables, an end-of-request marker and the request tag.
//
// Ports
//   sys_clk, sys_rst                 clock, synchronous active-high reset
//   req_addr/len/tag/valid, req_ready    read request (byte address, byte length, tag)
//   dma_cmd_rd_en/addr/last, _ready      line read command toward the responder
//   dma_rd_resp_valid/data, _ready       in-order line responses (never refused)
//   m_axis_tdata/tkeep/tlast/tuser/tvalid, m_axis_tready   framed output stream
//   busy                                 request in progress or lines still in flight
module core_dma_rd_initiator #(
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH      = 22,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned TAG_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  dma_cmd_rd_en,
  output logic [ADDR_WIDTH-1:0] dma_cmd_rd_addr,
  output logic                  dma_cmd_rd_last,
  input  logic                  dma_cmd_rd_ready,
  input  logic                  dma_rd_resp_valid,
  input  logic [DATA_WIDTH-1:0] dma_rd_resp_data,
  output logic                  dma_rd_resp_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [STRB_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [TAG_WIDTH-1:0]  m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy
);

  localparam int unsigned OFF_W  = $clog2(STRB_WIDTH);
  localparam int unsigned BEAT_W = LEN_WIDTH - OFF_W + 1;
  localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CRD_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned META_W = STRB_WIDTH + 1 + TAG_WIDTH;

  localparam logic [CRD_W-1:0]      CrdMax   = CRD_W'(MAX_OUTSTANDING);
  localparam logic [CRD_W-1:0]      CrdOne   = CRD_W'(1);
  localparam logic [BEAT_W-1:0]     BeatOne  = BEAT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] LineStep = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [PTR_W:0]        PtrOne   = (PTR_W + 1)'(1);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BEAT_W-1:0]     r_beats_left;
  logic [OFF_W-1:0]      r_tail;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [CRD_W-1:0]      r_credits;

  logic [META_W-1:0]     r_meta_mem [MAX_OUTSTANDING];
  logic [PTR_W:0]        r_meta_wptr, r_meta_rptr;
  logic [DATA_WIDTH-1:0] r_data_mem [MAX_OUTSTANDING];
  logic [PTR_W:0]        r_data_wptr, r_data_rptr;

  logic                  w_req_fire, w_cmd_en, w_cmd_fire, w_cmd_last;
  logic                  w_resp_fire, w_out_valid, w_out_fire;
  logic                  w_meta_empty, w_data_empty, w_data_full;
  logic [BEAT_W-1:0]     w_req_beats;
  logic [STRB_WIDTH-1:0] w_tail_mask, w_keep;
  logic [META_W-1:0]     w_meta_in, w_meta_head;
  logic [DATA_WIDTH-1:0] w_data_head;
  logic                  w_unused_addr_lo;

  // Request address is line aligned; the low offset bits carry no information.
  assign w_unused_addr_lo = ^req_addr[OFF_W-1:0];

  assign req_ready   = (r_state == StIdle) && !sys_rst;
  assign w_req_fire  = req_ready && req_valid;
  assign w_req_beats = BEAT_W'(req_len[LEN_WIDTH-1:OFF_W]) + BEAT_W'(req_len[OFF_W-1:0] != '0);

  // A command only goes out with a free credit, which reserves room in both FIFOs.
  assign w_cmd_en   = (r_state == StIssue) && (r_credits != '0) && !sys_rst;
  assign w_cmd_fire = w_cmd_en && dma_cmd_rd_ready;
  assign w_cmd_last = (r_beats_left == BeatOne);

  assign w_meta_empty = (r_meta_wptr == r_meta_rptr);
  assign w_data_empty = (r_data_wptr == r_data_rptr);
  assign w_data_full  = ((r_data_wptr ^ r_data_rptr) == {1'b1, {PTR_W{1'b0}}});

  assign w_resp_fire = dma_rd_resp_valid && !sys_rst;
  assign w_out_valid = !w_meta_empty && !w_data_empty && !sys_rst;
  assign w_out_fire  = w_out_valid && m_axis_tready;

  always_comb begin
    w_tail_mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      w_tail_mask[i] = (i < int'(r_tail));
    end
    w_keep = (w_cmd_last && (r_tail != '0)) ? w_tail_mask : '1;
  end

  assign w_meta_in   = {w_keep, w_cmd_last, r_tag};
  assign w_meta_head = r_meta_mem[r_meta_rptr[PTR_W-1:0]];
  assign w_data_head = r_data_mem[r_data_rptr[PTR_W-1:0]];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_req_fire && (req_len != '0)) w_state_nxt = StIssue;
      StIssue: if (w_cmd_fire && w_cmd_last) w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_beats_left <= '0;
      r_tail       <= '0;
      r_tag        <= '0;
      r_credits    <= CrdMax;
      r_meta_wptr  <= '0;
      r_meta_rptr  <= '0;
      r_data_wptr  <= '0;
      r_data_rptr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) begin
        r_addr       <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        r_beats_left <= w_req_beats;
        r_tail       <= req_len[OFF_W-1:0];
        r_tag        <= req_tag;
      end else if (w_cmd_fire) begin
        r_addr       <= r_addr + LineStep;
        r_beats_left <= r_beats_left - BeatOne;
      end
      unique case ({w_cmd_fire, w_out_fire})
        2'b10:   r_credits <= r_credits - CrdOne;
        2'b01:   r_credits <= r_credits + CrdOne;
        default: r_credits <= r_credits;
      endcase
      if (w_cmd_fire) r_meta_wptr <= r_meta_wptr + PtrOne;
      if (w_resp_fire) r_data_wptr <= r_data_wptr + PtrOne;
      if (w_out_fire) begin
        r_meta_rptr <= r_meta_rptr + PtrOne;
        r_data_rptr <= r_data_rptr + PtrOne;
      end
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_cmd_fire) r_meta_mem[r_meta_wptr[PTR_W-1:0]] <= w_meta_in;
    if (w_resp_fire) r_data_mem[r_data_wptr[PTR_W-1:0]] <= dma_rd_resp_data;
  end

  assign dma_cmd_rd_en     = w_cmd_en;
  assign dma_cmd_rd_addr   = sys_rst ? '0 : r_addr;
  assign dma_cmd_rd_last   = (r_state == StIssue) && w_cmd_last && !sys_rst;
  assign dma_rd_resp_ready = !sys_rst;
  assign m_axis_tvalid     = w_out_valid;
  assign m_axis_tdata      = w_out_valid ? w_data_head : '0;
  assign {m_axis_tkeep, m_axis_tlast, m_axis_tuser} = w_out_valid ? w_meta_head : '0;
  assign busy = !sys_rst && ((r_state != StIdle) || (r_credits != CrdMax));

  // Credits bound in-flight lines, so the response FIFO can never overflow.
  a_resp_no_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
    dma_rd_resp_valid |-> !w_data_full);
  a_credit_bound: assert property (@(posedge sys_clk) disable iff (sys_rst)
    r_credits <= CrdMax);

endmodule

// File: tb/tb_core_dma_rd_initiator.sv
module tb_core_dma_rd_initiator;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic [21:0]  req_addr;
  logic [15:0]  req_len;
  logic [7:0]   req_tag;
  logic         req_valid, req_ready;
  logic         dma_cmd_rd_en, dma_cmd_rd_last, dma_cmd_rd_ready;
  logic [21:0]  dma_cmd_rd_addr;
  logic         dma_rd_resp_valid, dma_rd_resp_ready;
  logic [127:0] dma_rd_resp_data;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [7:0]   m_axis_tuser;
  logic         busy;

  core_dma_rd_initiator dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .req_tag          (req_tag),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .dma_cmd_rd_en    (dma_cmd_rd_en),
    .dma_cmd_rd_addr  (dma_cmd_rd_addr),
    .dma_cmd_rd_last  (dma_cmd_rd_last),
    .dma_cmd_rd_ready (dma_cmd_rd_ready),
    .dma_rd_resp_valid(dma_rd_resp_valid),
    .dma_rd_resp_data (dma_rd_resp_data),
    .dma_rd_resp_ready(dma_rd_resp_ready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .busy             (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [21:0] addr;
    logic        last;
    int          cyc;
  } cmd_t;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [7:0]   user;
    int           cyc;
  } beat_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  cmd_t        cmd_q[$];
  beat_t       out_q[$];
  int          resp_cyc_q[$];
  logic [21:0] pend_q[$];
  logic        cmd_hs_f = 1'b0;
  logic        resp_hs_f = 1'b0;
  logic        clr_pend = 1'b0;
  logic [21:0] cmd_addr_f = '0;
  logic        stress_en = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Responder data pattern, derived from the line address.
  function automatic logic [127:0] exp_data(input logic [21:0] a);
    logic [31:0] w;
    w = {10'h2A5, a};
    return {w ^ 32'hDEADBEEF, ~w, w ^ 32'h13579BDF, w};
  endfunction

  // Monitor: handshakes sampled mid-cycle, they complete at the next rising edge.
  initial begin
    cmd_t  c;
    beat_t b;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        clr_pend  = 1'b1;
        cmd_hs_f  = 1'b0;
        resp_hs_f = 1'b0;
      end else begin
        cmd_hs_f   = dma_cmd_rd_en && dma_cmd_rd_ready;
        cmd_addr_f = dma_cmd_rd_addr;
        if (cmd_hs_f) begin
          c.addr = dma_cmd_rd_addr;
          c.last = dma_cmd_rd_last;
          c.cyc  = cyc;
          cmd_q.push_back(c);
        end
        resp_hs_f = dma_rd_resp_valid && dma_rd_resp_ready;
        if (resp_hs_f) resp_cyc_q.push_back(cyc);
        if (m_axis_tvalid && m_axis_tready) begin
          b.data = m_axis_tdata;
          b.keep = m_axis_tkeep;
          b.last = m_axis_tlast;
          b.user = m_axis_tuser;
          b.cyc  = cyc;
          out_q.push_back(b);
        end
      end
    end
  end

  // In-order responder sharing sys_rst with the DUT.
  initial begin
    dma_rd_resp_valid = 1'b0;
    dma_rd_resp_data  = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (clr_pend) begin
        pend_q.delete();
        clr_pend = 1'b0;
      end else begin
        if (resp_hs_f) pend_q.delete(0);
        if (cmd_hs_f) pend_q.push_back(cmd_addr_f);
      end
      resp_hs_f = 1'b0;
      cmd_hs_f  = 1'b0;
      if (pend_q.size() > 0 && (!stress_en || $urandom_range(0, 3) != 0)) begin
        dma_rd_resp_valid = 1'b1;
        dma_rd_resp_data  = exp_data(pend_q[0]);
      end else begin
        dma_rd_resp_valid = 1'b0;
        dma_rd_resp_data  = '0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (stress_en) begin
        dma_cmd_rd_ready = ($urandom_range(0, 2) != 0);
        m_axis_tready    = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    cmd_q.delete();
    out_q.delete();
    resp_cyc_q.delete();
  endtask

  task automatic do_req(input logic [21:0] a, input logic [15:0] l, input logic [7:0] t,
                        output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    @(posedge sys_clk);
    #1;
    req_addr  = a;
    req_len   = l;
    req_tag   = t;
    req_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      if (req_ready) begin
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    @(posedge sys_clk);
    #1;
    req_valid = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL req_accept: req_ready never seen, addr=%h len=%0d", a, l);
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge sys_clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle: busy still %b after %0d cycles, required 0", name, busy, max_cyc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if ({req_ready, dma_cmd_rd_en, dma_cmd_rd_last, m_axis_tvalid, m_axis_tlast, busy,
         dma_rd_resp_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy=%b en=%b last=%b tv=%b tl=%b busy=%b rr=%b, required all 0",
               req_ready, dma_cmd_rd_en, dma_cmd_rd_last, m_axis_tvalid, m_axis_tlast, busy,
               dma_rd_resp_ready);
    end
    n_tests++;
    if (dma_cmd_rd_addr !== '0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 ||
        m_axis_tuser !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h data=%h keep=%h user=%h, required 0",
               dma_cmd_rd_addr, m_axis_tdata, m_axis_tkeep, m_axis_tuser);
    end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_tests++;
    if ({req_ready, dma_rd_resp_ready, busy, dma_cmd_rd_en, m_axis_tvalid} !== 5'b11000) begin
      n_fail++;
      $display("FAIL post_reset: rdy=%b rr=%b busy=%b en=%b tv=%b, required 1 1 0 0 0",
               req_ready, dma_rd_resp_ready, busy, dma_cmd_rd_en, m_axis_tvalid);
    end
  endtask

  task automatic test_basic();
    int acc;
    logic [21:0] ea;
    clear_q();
    dma_cmd_rd_ready = 1'b1;
    m_axis_tready    = 1'b1;
    do_req(22'h001000, 16'd64, 8'h5A, acc);
    wait_idle(200, "basic");
    n_tests++;
    if (cmd_q.size() != 4 || out_q.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count: cmds=%0d beats=%0d, required 4 4", cmd_q.size(), out_q.size());
    end
    for (int i = 0; i < 4 && i < cmd_q.size() && i < out_q.size(); i++) begin
      ea = 22'h001000 + 22'(16 * i);
      n_tests++;
      if (cmd_q[i].addr !== ea || cmd_q[i].last !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_cmd[%0d]: addr=%h last=%b, required %h %b",
                 i, cmd_q[i].addr, cmd_q[i].last, ea, (i == 3));
      end
      n_tests++;
      if (out_q[i].data !== exp_data(ea) || out_q[i].keep !== 16'hFFFF ||
          out_q[i].last !== (i == 3) || out_q[i].user !== 8'h5A) begin
        n_fail++;
        $display("FAIL basic_beat[%0d]: data=%h keep=%h last=%b user=%h, required %h FFFF %b 5a",
                 i, out_q[i].data, out_q[i].keep, out_q[i].last, out_q[i].user, exp_data(ea),
                 (i == 3));
      end
    end
    if (cmd_q.size() > 0) begin
      n_tests++;
      if (cmd_q[0].cyc - acc !== 1) begin
        n_fail++;
        $display("FAIL basic_cmd_latency: %0d cycles, required 1", cmd_q[0].cyc - acc);
      end
    end
    if (out_q.size() > 0 && resp_cyc_q.size() > 0) begin
      n_tests++;
      if (out_q[0].cyc - resp_cyc_q[0] !== 1) begin
        n_fail++;
        $display("FAIL basic_resp_latency: %0d cycles, required 1", out_q[0].cyc - resp_cyc_q[0]);
      end
    end
  endtask

  task automatic test_short_tail();
    int acc;
    clear_q();
    do_req(22'h002000, 16'd17, 8'h11, acc);
    wait_idle(200, "len17");
    n_tests++;
    if (cmd_q.size() != 2 || out_q.size() != 2) begin
      n_fail++;
      $display("FAIL len17_count: cmds=%0d beats=%0d, required 2 2", cmd_q.size(), out_q.size());
    end else begin
      n_tests++;
      if (cmd_q[0].last !== 1'b0 || cmd_q[1].last !== 1'b1 || cmd_q[1].addr !== 22'h002010) begin
        n_fail++;
        $display("FAIL len17_cmd: last0=%b last1=%b addr1=%h, required 0 1 002010",
                 cmd_q[0].last, cmd_q[1].last, cmd_q[1].addr);
      end
      n_tests++;
      if (out_q[0].keep !== 16'hFFFF || out_q[0].last !== 1'b0 || out_q[1].keep !== 16'h0001 ||
          out_q[1].last !== 1'b1 || out_q[1].data !== exp_data(22'h002010)) begin
        n_fail++;
        $display("FAIL len17_beats: keep0=%h last0=%b keep1=%h last1=%b, required FFFF 0 0001 1",
                 out_q[0].keep, out_q[0].last, out_q[1].keep, out_q[1].last);
      end
    end
    clear_q();
    do_req(22'h002005, 16'd1, 8'h22, acc);
    wait_idle(200, "len1");
    n_tests++;
    if (cmd_q.size() != 1 || out_q.size() != 1) begin
      n_fail++;
      $display("FAIL len1_count: cmds=%0d beats=%0d, required 1 1", cmd_q.size(), out_q.size());
    end else begin
      n_tests++;
      if (cmd_q[0].addr !== 22'h002000 || cmd_q[0].last !== 1'b1 || out_q[0].keep !== 16'h0001 ||
          out_q[0].last !== 1'b1 || out_q[0].user !== 8'h22) begin
        n_fail++;
        $display("FAIL len1: addr=%h clast=%b keep=%h tlast=%b user=%h, required 002000 1 0001 1 22",
                 cmd_q[0].addr, cmd_q[0].last, out_q[0].keep, out_q[0].last, out_q[0].user);
      end
    end
    clear_q();
    do_req(22'h003000, 16'd0, 8'h33, acc);
    @(negedge sys_clk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_ready: req_ready=%b busy=%b, required 1 0", req_ready, busy);
    end
    repeat (10) @(negedge sys_clk);
    n_tests++;
    if (cmd_q.size() != 0 || out_q.size() != 0) begin
      n_fail++;
      $display("FAIL len0_quiet: cmds=%0d beats=%0d, required 0 0", cmd_q.size(), out_q.size());
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [21:0] ea;
    clear_q();
    m_axis_tready = 1'b0;
    do_req(22'h004000, 16'd256, 8'h44, acc);
    repeat (30) @(negedge sys_clk);
    n_tests++;
    if (cmd_q.size() != 8 || dma_cmd_rd_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: cmds=%0d en=%b busy=%b, required 8 0 1",
               cmd_q.size(), dma_cmd_rd_en, busy);
    end
    n_tests++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_data(22'h004000) ||
        m_axis_tkeep !== 16'hFFFF || m_axis_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: tvalid=%b data=%h keep=%h last=%b, required 1 %h FFFF 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, exp_data(22'h004000));
    end
    @(posedge sys_clk);
    #1;
    m_axis_tready = 1'b1;
    wait_idle(300, "bp");
    n_tests++;
    if (cmd_q.size() != 16 || out_q.size() != 16) begin
      n_fail++;
      $display("FAIL bp_count: cmds=%0d beats=%0d, required 16 16", cmd_q.size(), out_q.size());
    end
    for (int i = 0; i < 16 && i < cmd_q.size() && i < out_q.size(); i++) begin
      ea = 22'h004000 + 22'(16 * i);
      n_tests++;
      if (cmd_q[i].addr !== ea || out_q[i].data !== exp_data(ea) ||
          out_q[i].last !== (i == 15) || out_q[i].user !== 8'h44) begin
        n_fail++;
        $display("FAIL bp_beat[%0d]: addr=%h data=%h last=%b user=%h, required %h %h %b 44",
                 i, cmd_q[i].addr, out_q[i].data, out_q[i].last, out_q[i].user, ea,
                 exp_data(ea), (i == 15));
      end
    end
  endtask

  task automatic test_addr_wrap();
    int acc;
    clear_q();
    do_req(22'h3FFFF7, 16'd32, 8'h77, acc);
    wait_idle(200, "wrap");
    n_tests++;
    if (cmd_q.size() != 2 || out_q.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_count: cmds=%0d beats=%0d, required 2 2", cmd_q.size(), out_q.size());
    end else begin
      n_tests++;
      if (cmd_q[0].addr !== 22'h3FFFF0 || cmd_q[1].addr !== 22'h000000 ||
          cmd_q[1].last !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_addr: %h %h last=%b, required 3ffff0 000000 1",
                 cmd_q[0].addr, cmd_q[1].addr, cmd_q[1].last);
      end
      n_tests++;
      if (out_q[1].keep !== 16'hFFFF || out_q[1].data !== exp_data(22'h000000)) begin
        n_fail++;
        $display("FAIL wrap_beat: keep=%h data=%h, required FFFF %h",
                 out_q[1].keep, out_q[1].data, exp_data(22'h000000));
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    logic [21:0] ea;
    logic [7:0]  eu;
    clear_q();
    do_req(22'h010000, 16'd48, 8'h01, acc1);
    do_req(22'h020000, 16'd32, 8'h02, acc2);
    wait_idle(200, "b2b");
    n_tests++;
    if (cmd_q.size() != 5 || out_q.size() != 5) begin
      n_fail++;
      $display("FAIL b2b_count: cmds=%0d beats=%0d, required 5 5", cmd_q.size(), out_q.size());
    end else begin
      n_tests++;
      if (!(acc2 < out_q[2].cyc)) begin
        n_fail++;
        $display("FAIL b2b_overlap: second accept at %0d, first last beat at %0d, required earlier",
                 acc2, out_q[2].cyc);
      end
      for (int i = 0; i < 5; i++) begin
        ea = (i < 3) ? 22'h010000 + 22'(16 * i) : 22'h020000 + 22'(16 * (i - 3));
        eu = (i < 3) ? 8'h01 : 8'h02;
        n_tests++;
        if (out_q[i].data !== exp_data(ea) || out_q[i].user !== eu ||
            out_q[i].last !== (i == 2 || i == 4)) begin
          n_fail++;
          $display("FAIL b2b_beat[%0d]: data=%h user=%h last=%b, required %h %h %b",
                   i, out_q[i].data, out_q[i].user, out_q[i].last, exp_data(ea), eu,
                   (i == 2 || i == 4));
        end
      end
    end
  endtask

  task automatic test_stress_reset();
    int acc;
    logic [21:0] ea;
    clear_q();
    stress_en = 1'b1;
    do_req(22'h030000, 16'd128, 8'h55, acc);
    wait_idle(3000, "stress");
    stress_en = 1'b0;
    n_tests++;
    if (out_q.size() != 8 || cmd_q.size() != 8) begin
      n_fail++;
      $display("FAIL stress_count: cmds=%0d beats=%0d, required 8 8", cmd_q.size(), out_q.size());
    end
    for (int i = 0; i < 8 && i < out_q.size() && i < cmd_q.size(); i++) begin
      ea = 22'h030000 + 22'(16 * i);
      n_tests++;
      if (cmd_q[i].addr !== ea || out_q[i].data !== exp_data(ea) || out_q[i].last !== (i == 7)) begin
        n_fail++;
        $display("FAIL stress_beat[%0d]: addr=%h data=%h last=%b, required %h %h %b",
                 i, cmd_q[i].addr, out_q[i].data, out_q[i].last, ea, exp_data(ea), (i == 7));
      end
    end
    stress_en = 1'b1;
    do_req(22'h040000, 16'd256, 8'h66, acc);
    repeat (20) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    stress_en        = 1'b0;
    dma_cmd_rd_ready = 1'b1;
    m_axis_tready    = 1'b1;
    sys_rst          = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if ({req_ready, dma_cmd_rd_en, dma_cmd_rd_last, m_axis_tvalid, m_axis_tlast, busy,
         dma_rd_resp_ready} !== 7'b0 || dma_cmd_rd_addr !== '0 || m_axis_tdata !== '0 ||
        m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rdy=%b en=%b tv=%b busy=%b addr=%h keep=%h, required 0",
               req_ready, dma_cmd_rd_en, m_axis_tvalid, busy, dma_cmd_rd_addr, m_axis_tkeep);
    end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: busy=%b req_ready=%b tvalid=%b, required 0 1 0",
               busy, req_ready, m_axis_tvalid);
    end
    clear_q();
    do_req(22'h005000, 16'd16, 8'h99, acc);
    wait_idle(200, "postreset");
    n_tests++;
    if (out_q.size() != 1 || cmd_q.size() != 1) begin
      n_fail++;
      $display("FAIL postreset_count: cmds=%0d beats=%0d, required 1 1", cmd_q.size(), out_q.size());
    end else begin
      n_tests++;
      if (out_q[0].data !== exp_data(22'h005000) || out_q[0].keep !== 16'hFFFF ||
          out_q[0].last !== 1'b1 || out_q[0].user !== 8'h99) begin
        n_fail++;
        $display("FAIL postreset_beat: data=%h keep=%h last=%b user=%h, required %h FFFF 1 99",
                 out_q[0].data, out_q[0].keep, out_q[0].last, out_q[0].user,
                 exp_data(22'h005000));
      end
    end
  endtask

  initial begin
    sys_rst          = 1'b1;
    req_valid        = 1'b0;
    req_addr         = '0;
    req_len          = '0;
    req_tag          = '0;
    dma_cmd_rd_ready = 1'b0;
    m_axis_tready    = 1'b0;
    test_reset();
    test_basic();
    test_short_tail();
    test_backpressure();
    test_addr_wrap();
    test_back_to_back();
    test_stress_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
